// File: rtl/result_seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : result_seg_scan_pkg
//  Description : Shared constants for the two-digit 7-segment result display.
//                Segment patterns are active high, bit order g..a ([6]=g).
//  Revision    : 1.0 - initial release
// ============================================================================
package result_seg_scan_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Full 8-bit segment word (dp included) with every segment dark.
    localparam logic [7:0] SEG_BLANK = 8'h00;
    // Both digit anodes off.
    localparam logic [1:0] AN_OFF    = 2'b00;

endpackage
`default_nettype wire

// File: rtl/result_seg_scan_hex.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg
//  Description : Combinational hex nibble to 7-segment (g..a) decoder.
//  Ports       : nibble [3:0] in  - value to display
//                seg    [6:0] out - active-high segment pattern, [6]=g
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
    import result_seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/result_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : result_seg_scan
//  Description : Latches an 8-bit result and scans it onto two multiplexed
//                7-segment digits with dead time between slots, optional
//                leading-zero blanking and a display enable.
//  Ports       : sysclk              in  - system clock
//                reset               in  - synchronous, active-high reset
//                result_in    [7:0]  in  - {nibble_hi, nibble_lo}
//                result_valid        in  - latch result_in on this edge
//                display_en          in  - 0 forces anodes off (scan runs on)
//                seg_an       [1:0]  out - anodes, [1]=high nibble digit
//                seg_out      [7:0]  out - segments, [7]=dp (0), [6:0]=g..a
//  Revision    : 1.0 - initial release
// ============================================================================
module result_seg_scan
    import result_seg_scan_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int DEAD_CYC   = 2,
    parameter bit BLANK_LEAD = 1'b0
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] result_in,
    input  logic       result_valid,
    input  logic       display_en,
    output logic [1:0] seg_an,
    output logic [7:0] seg_out
);

    localparam int              CNT_W  = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] c_term = CNT_W'(SCAN_DIV - 1);

    logic [7:0]       r_held;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic [1:0]       r_seg_an;
    logic [7:0]       r_seg_out;

    logic             w_dead;
    logic [3:0]       w_nibble;
    logic [6:0]       w_seg7;
    logic [1:0]       w_an_nxt;
    logic [7:0]       w_seg_nxt;

    // Dead time only exists when DEAD_CYC > 0; avoids a constant compare.
    generate
        if (DEAD_CYC > 0) begin : g_dead
            localparam logic [CNT_W-1:0] c_dead_cyc = CNT_W'(DEAD_CYC);
            assign w_dead = (r_cnt < c_dead_cyc);
        end else begin : g_no_dead
            assign w_dead = 1'b0;
        end
    endgenerate

    assign w_nibble = r_sel ? r_held[7:4] : r_held[3:0];

    hex_to_seg u_hex_to_seg (
        .nibble (w_nibble),
        .seg    (w_seg7)
    );

    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_BLANK;
        if (w_dead || !display_en) begin
            w_an_nxt  = AN_OFF;
            w_seg_nxt = SEG_BLANK;
        end else if (r_sel && BLANK_LEAD && (r_held[7:4] == 4'h0)) begin
            w_an_nxt  = AN_OFF;
            w_seg_nxt = SEG_BLANK;
        end else begin
            w_an_nxt  = r_sel ? 2'b10 : 2'b01;
            w_seg_nxt = {1'b0, w_seg7};
        end
    end

    // Outputs are computed from the pre-edge scan state, giving one cycle
    // of latency; a latch never disturbs the prescaler or digit select.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_held    <= 8'h00;
            r_cnt     <= '0;
            r_sel     <= 1'b0;
            r_seg_an  <= AN_OFF;
            r_seg_out <= SEG_BLANK;
        end else begin
            if (result_valid) begin
                r_held <= result_in;
            end
            if (r_cnt == c_term) begin
                r_cnt <= '0;
                r_sel <= ~r_sel;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_seg_an  <= w_an_nxt;
            r_seg_out <= w_seg_nxt;
        end
    end

    assign seg_an  = r_seg_an;
    assign seg_out = r_seg_out;

endmodule
`default_nettype wire
